gpu_launch_ctrl: RTL and testbench

GPU_LAUNCH_CTRL -- requirements
Module: gpu_launch_ctrl

---
 rtl/gpu_launch_ctrl.sv | 149 ++++++++++++++
 tb/tb_gpu_launch_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_launch_ctrl.sv
// Kernel launch sequencer: IDLE -> CLR -> RUN -> FIN around a compute core.
// Define GPU_LAUNCH_TIMEOUT_EN to compile in the RUN watchdog.
module gpu_launch_ctrl #(
  parameter int DMEM_AW     = 10,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [9:0]         cmd_n_words,
  input  logic [DMEM_AW-1:0] cmd_a_base,
  input  logic [DMEM_AW-1:0] cmd_b_base,
  input  logic [DMEM_AW-1:0] cmd_c_base,
  output logic               core_rst,
  output logic               core_run,
  output logic [9:0]         core_n_words,
  output logic [DMEM_AW-1:0] core_a_base,
  output logic [DMEM_AW-1:0] core_b_base,
  output logic [DMEM_AW-1:0] core_c_base,
  input  logic               core_done,
  output logic               busy,
  output logic               kdone,
  output logic [31:0]        cyc_count,
  output logic               err_timeout,
  output logic               host_dmem_gnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_FIN
  } state_t;

`ifdef GPU_LAUNCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYC);

  state_t             r_state;
  logic               r_clr_cnt;
  logic               r_core_rst;
  logic               r_core_run;
  logic               r_kdone;
  logic               r_busy;
  logic               r_cmd_ready;
  logic               r_gnt;
  logic               r_err;
  logic [31:0]        r_cyc;
  logic [9:0]         r_n_words;
  logic [DMEM_AW-1:0] r_a_base;
  logic [DMEM_AW-1:0] r_b_base;
  logic [DMEM_AW-1:0] r_c_base;

  logic [31:0] w_cyc_nxt;
  logic        w_to_hit;

  // count saturates instead of wrapping
  assign w_cyc_nxt = (&r_cyc) ? r_cyc : r_cyc + 32'd1;
  assign w_to_hit  = TO_EN && (r_cyc == TO_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_clr_cnt   <= 1'b0;
      r_core_rst  <= 1'b1;
      r_core_run  <= 1'b0;
      r_kdone     <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_gnt       <= 1'b1;
      r_err       <= 1'b0;
      r_cyc       <= '0;
      r_n_words   <= '0;
      r_a_base    <= '0;
      r_b_base    <= '0;
      r_c_base    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_core_rst <= 1'b0;
          if (cmd_valid) begin
            r_state     <= S_CLR;
            r_clr_cnt   <= 1'b1;
            r_core_rst  <= 1'b1;
            r_busy      <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_gnt       <= 1'b0;
            r_err       <= 1'b0;
            r_cyc       <= '0;
            r_n_words   <= cmd_n_words;
            r_a_base    <= cmd_a_base;
            r_b_base    <= cmd_b_base;
            r_c_base    <= cmd_c_base;
          end
        end
        S_CLR: begin
          if (r_clr_cnt) begin
            r_clr_cnt <= 1'b0;
          end else begin
            r_state    <= S_RUN;
            r_core_rst <= 1'b0;
            r_core_run <= 1'b1;
          end
        end
        S_RUN: begin
          r_cyc <= w_cyc_nxt;
          if (core_done) begin
            r_state    <= S_FIN;
            r_core_run <= 1'b0;
            r_kdone    <= 1'b1;
          end else if (w_to_hit) begin
            r_state    <= S_FIN;
            r_core_run <= 1'b0;
            r_core_rst <= 1'b1;
            r_kdone    <= 1'b1;
            r_err      <= 1'b1;
          end
        end
        S_FIN: begin
          r_state     <= S_IDLE;
          r_kdone     <= 1'b0;
          r_core_rst  <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_gnt       <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign core_rst      = r_core_rst;
  assign core_run      = r_core_run;
  assign core_n_words  = r_n_words;
  assign core_a_base   = r_a_base;
  assign core_b_base   = r_b_base;
  assign core_c_base   = r_c_base;
  assign busy          = r_busy;
  assign kdone         = r_kdone;
  assign cyc_count     = r_cyc;
  assign err_timeout   = r_err;
  assign host_dmem_gnt = r_gnt;

endmodule

// File: tb/tb_gpu_launch_ctrl.sv
// Self-checking bench for gpu_launch_ctrl: vector table, corner sequences,
// random launches against a cycle-count reference model.
module tb_gpu_launch_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [9:0]    cmd_n_words;
  logic [AW-1:0] cmd_a_base;
  logic [AW-1:0] cmd_b_base;
  logic [AW-1:0] cmd_c_base;
  logic          core_rst;
  logic          core_run;
  logic [9:0]    core_n_words;
  logic [AW-1:0] core_a_base;
  logic [AW-1:0] core_b_base;
  logic [AW-1:0] core_c_base;
  logic          core_done;
  logic          busy;
  logic          kdone;
  logic [31:0]   cyc_count;
  logic          err_timeout;
  logic          host_dmem_gnt;

  int checks = 0;
  int failures = 0;

  gpu_launch_ctrl #(
    .DMEM_AW    (AW),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_n_words  (cmd_n_words),
    .cmd_a_base   (cmd_a_base),
    .cmd_b_base   (cmd_b_base),
    .cmd_c_base   (cmd_c_base),
    .core_rst     (core_rst),
    .core_run     (core_run),
    .core_n_words (core_n_words),
    .core_a_base  (core_a_base),
    .core_b_base  (core_b_base),
    .core_c_base  (core_c_base),
    .core_done    (core_done),
    .busy         (busy),
    .kdone        (kdone),
    .cyc_count    (cyc_count),
    .err_timeout  (err_timeout),
    .host_dmem_gnt(host_dmem_gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]    n;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] c;
    int            dly;
    bit            stale;
    int            exp_cyc;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: a kernel whose done arrives dly cycles after RUN entry
  // occupies dly+1 RUN cycles, all of which are counted.
  function automatic int ref_cycles(input int dly);
    return dly + 1;
  endfunction

  task automatic chk_args(input string nm, input logic [9:0] n,
                          input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [AW-1:0] c);
    chk({nm, "_n"}, 32'(core_n_words), 32'(n));
    chk({nm, "_a"}, 32'(core_a_base), 32'(a));
    chk({nm, "_b"}, 32'(core_b_base), 32'(b));
    chk({nm, "_c"}, 32'(core_c_base), 32'(c));
  endtask

  // Called one step after a rising edge while the DUT is in IDLE.
  task automatic run_kernel(input string nm, input logic [9:0] n,
                            input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input logic [AW-1:0] c, input int dly,
                            input bit stale, input bit hold,
                            input int exp_cyc);
    int nrst;
    int t;
    int k;
    chk({nm, "_ready_idle"}, 32'(cmd_ready), 1);
    chk({nm, "_gnt_idle"}, 32'(host_dmem_gnt), 1);
    cmd_valid = 1'b1;
    cmd_n_words = n;
    cmd_a_base = a;
    cmd_b_base = b;
    cmd_c_base = c;
    core_done = stale;
    step();
    if (!hold) cmd_valid = 1'b0;
    chk({nm, "_busy_clr"}, 32'(busy), 1);
    chk({nm, "_cyc_clr"}, cyc_count, 0);
    chk({nm, "_err_clr"}, 32'(err_timeout), 0);
    chk({nm, "_ready_clr"}, 32'(cmd_ready), 0);
    chk({nm, "_gnt_clr"}, 32'(host_dmem_gnt), 0);
    chk_args({nm, "_args_clr"}, n, a, b, c);
    nrst = 0;
    t = 0;
    while (!core_run && t < 10) begin
      if (core_rst) nrst++;
      step();
      t++;
    end
    chk({nm, "_run_entry"}, 32'(core_run), 1);
    chk({nm, "_rst_cycles"}, 32'(nrst), 2);
    chk({nm, "_rst_in_run"}, 32'(core_rst), 0);
    core_done = 1'b0;
    k = 0;
    while (!kdone && k < 300) begin
      if (k == dly) core_done = 1'b1;
      if (k == 1) chk({nm, "_cyc_first"}, cyc_count, 1);
      step();
      k++;
    end
    chk({nm, "_kdone"}, 32'(kdone), 1);
    chk({nm, "_run_cycles"}, 32'(k), 32'(exp_cyc));
    chk({nm, "_cyc_fin"}, cyc_count, 32'(exp_cyc));
    chk({nm, "_run_fin"}, 32'(core_run), 0);
    chk({nm, "_busy_fin"}, 32'(busy), 1);
    chk({nm, "_err_fin"}, 32'(err_timeout), 0);
    chk_args({nm, "_args_fin"}, n, a, b, c);
    core_done = 1'b0;
    step();
    chk({nm, "_kdone_pulse"}, 32'(kdone), 0);
    chk({nm, "_busy_idle"}, 32'(busy), 0);
    chk({nm, "_cyc_hold"}, cyc_count, 32'(exp_cyc));
    chk({nm, "_rst_idle"}, 32'(core_rst), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int kd;
    int nrun;
    vecs[0] = '{10'd4, 10'h000, 10'h100, 10'h200, 10, 1'b0, 11};
    vecs[1] = '{10'd1, 10'h3FF, 10'h001, 10'h2AA, 0, 1'b0, 1};
    vecs[2] = '{10'd1023, 10'h155, 10'h0AA, 10'h3FF, 3, 1'b1, 4};
    vecs[3] = '{10'd0, 10'h000, 10'h000, 10'h000, 1, 1'b0, 2};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_n_words = '0;
    cmd_a_base = '0;
    cmd_b_base = '0;
    cmd_c_base = '0;
    core_done = 1'b0;
    step();
    step();
    chk("rst_core_rst", 32'(core_rst), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_kdone", 32'(kdone), 0);
    chk("rst_run", 32'(core_run), 0);
    chk("rst_cyc", cyc_count, 0);
    chk("rst_err", 32'(err_timeout), 0);
    chk_args("rst_args", '0, '0, '0, '0);
    rst = 1'b0;
    step();
    chk("idle_core_rst", 32'(core_rst), 0);
    chk("idle_ready", 32'(cmd_ready), 1);
    chk("idle_gnt", 32'(host_dmem_gnt), 1);

    for (int i = 0; i < 4; i++) begin
      run_kernel($sformatf("vec%0d", i), vecs[i].n, vecs[i].a,
                 vecs[i].b, vecs[i].c, vecs[i].dly, vecs[i].stale,
                 1'b0, vecs[i].exp_cyc);
    end

    // back-to-back kernels with cmd_valid held throughout
    run_kernel("b2b_0", 10'd7, 10'h011, 10'h022, 10'h033, 5, 1'b0,
               1'b1, 6);
    run_kernel("b2b_1", 10'd9, 10'h044, 10'h055, 10'h066, 2, 1'b0,
               1'b0, 3);
    step();
    chk("b2b_no_third", 32'(busy), 0);

    // stale done from previous kernel during CLR
    run_kernel("stale", 10'd3, 10'h101, 10'h202, 10'h303, 6, 1'b1,
               1'b0, 7);

    // reset during RUN
    cmd_valid = 1'b1;
    cmd_n_words = 10'd5;
    cmd_a_base = 10'h0F0;
    cmd_b_base = 10'h0E0;
    cmd_c_base = 10'h0D0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("mid_run_entry", 32'(core_run), 1);
    for (int i = 0; i < 5; i++) step();
    chk("mid_cyc5", cyc_count, 5);
    rst = 1'b1;
    step();
    chk("mid_busy", 32'(busy), 0);
    chk("mid_cyc", cyc_count, 0);
    chk("mid_kdone", 32'(kdone), 0);
    chk("mid_run", 32'(core_run), 0);
    chk("mid_core_rst", 32'(core_rst), 1);
    chk_args("mid_args", '0, '0, '0, '0);
    rst = 1'b0;
    step();
    chk("mid_post_kdone", 32'(kdone), 0);
    chk("mid_post_ready", 32'(cmd_ready), 1);
    chk("mid_post_core_rst", 32'(core_rst), 0);

`ifdef GPU_LAUNCH_TIMEOUT_EN
    // watchdog expires with no done
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    kd = 0;
    nrun = 0;
    while (!kdone && kd < 100) begin
      if (core_run) nrun++;
      step();
      kd++;
    end
    chk("to_kdone", 32'(kdone), 1);
    chk("to_err", 32'(err_timeout), 1);
    chk("to_run_cycles", 32'(nrun), 17);
    step();
    chk("to_err_sticky", 32'(err_timeout), 1);
    chk("to_busy_idle", 32'(busy), 0);
    run_kernel("to_clear", 10'd2, 10'h010, 10'h020, 10'h030, 4, 1'b0,
               1'b0, 5);
    run_kernel("to_tie", 10'd2, 10'h011, 10'h021, 10'h031, 16, 1'b0,
               1'b0, 17);
`else
    // no watchdog: long kernel completes normally
    kd = 0;
    nrun = 0;
    run_kernel("nowd", 10'd8, 10'h1AA, 10'h2BB, 10'h3CC, 40, 1'b0,
               1'b0, ref_cycles(40));
    chk("nowd_err", 32'(err_timeout), 0);
`endif

    for (int i = 0; i < 8; i++) begin
      logic [9:0] rn;
      logic [AW-1:0] ra;
      logic [AW-1:0] rb;
      logic [AW-1:0] rc;
      int rd;
      bit rs;
      rn = 10'($urandom);
      ra = AW'($urandom);
      rb = AW'($urandom);
      rc = AW'($urandom);
      rd = int'($urandom_range(0, 14));
      rs = 1'($urandom);
      run_kernel($sformatf("rnd%0d", i), rn, ra, rb, rc, rd, rs, 1'b0,
                 ref_cycles(rd));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
